mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin between CPU and loader ports, one
// fixed-latency memory access at a time followed by a one-cycle response.
module mem_arbiter #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rd,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_adr,
  input  logic [DW-1:0] ld_wd,
  output logic          ld_ready,
  output logic [DW-1:0] ld_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic          last_owner_reg;  // 0 = CPU, 1 = loader
  logic          we_reg;
  logic [1:0]    grant_reg;
  logic          busy_reg;
  logic          mem_we_reg;
  logic          cpu_ready_reg;
  logic          ld_ready_reg;
  logic [AW-1:0] mem_adr_reg;
  logic [DW-1:0] mem_wd_reg;
  logic [DW-1:0] cpu_rd_reg;
  logic [DW-1:0] ld_rd_reg;

  logic          pick_ld;
  logic          sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wd;

  // On a tie the requester that did not own the previous access wins.
  always_comb begin
    pick_ld = ld_req & (~cpu_req | ~last_owner_reg);
    sel_we  = pick_ld ? ld_we  : cpu_we;
    sel_adr = pick_ld ? ld_adr : cpu_adr;
    sel_wd  = pick_ld ? ld_wd  : cpu_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      last_owner_reg <= 1'b1;
      we_reg         <= 1'b0;
      grant_reg      <= 2'b00;
      busy_reg       <= 1'b0;
      mem_we_reg     <= 1'b0;
      cpu_ready_reg  <= 1'b0;
      ld_ready_reg   <= 1'b0;
      mem_adr_reg    <= '0;
      mem_wd_reg     <= '0;
      cpu_rd_reg     <= '0;
      ld_rd_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cpu_ready_reg <= 1'b0;
          ld_ready_reg  <= 1'b0;
          if (cpu_req || ld_req) begin
            state_reg      <= ACCESS;
            cnt_reg        <= CNT_INIT;
            grant_reg      <= pick_ld ? 2'b10 : 2'b01;
            last_owner_reg <= pick_ld;
            busy_reg       <= 1'b1;
            we_reg         <= sel_we;
            mem_we_reg     <= sel_we;
            mem_adr_reg    <= sel_adr;
            mem_wd_reg     <= sel_wd;
          end
        end
        ACCESS: begin
          // The write strobe covers only the first access cycle.
          mem_we_reg <= 1'b0;
          if (cnt_reg == 4'd0) begin
            state_reg     <= RESP;
            cpu_ready_reg <= grant_reg[0];
            ld_ready_reg  <= grant_reg[1];
            if (!we_reg) begin
              if (grant_reg[1]) ld_rd_reg  <= mem_rd;
              else              cpu_rd_reg <= mem_rd;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg     <= IDLE;
          cpu_ready_reg <= 1'b0;
          ld_ready_reg  <= 1'b0;
          grant_reg     <= 2'b00;
          busy_reg      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready = cpu_ready_reg;
  assign ld_ready  = ld_ready_reg;
  assign cpu_rd    = cpu_rd_reg;
  assign ld_rd     = ld_rd_reg;
  assign mem_we    = mem_we_reg;
  assign mem_adr   = mem_adr_reg;
  assign mem_wd    = mem_wd_reg;
  assign grant     = grant_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random request rounds checked
// cycle by cycle against a transaction schedule derived from the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int LAT  = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_ready;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wd, cpu_rd;
  logic          ld_req, ld_we, ld_ready;
  logic [AW-1:0] ld_adr;
  logic [DW-1:0] ld_wd, ld_rd;
  logic          mem_we, busy;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd, mem_rd;
  logic [1:0]    grant;

  logic          d1_cpu_req, d1_cpu_we, d1_cpu_ready;
  logic [AW-1:0] d1_cpu_adr;
  logic [DW-1:0] d1_cpu_wd, d1_cpu_rd;
  logic          d1_ld_req, d1_ld_we, d1_ld_ready;
  logic [AW-1:0] d1_ld_adr;
  logic [DW-1:0] d1_ld_wd, d1_ld_rd;
  logic          d1_mem_we, d1_busy;
  logic [AW-1:0] d1_mem_adr;
  logic [DW-1:0] d1_mem_wd, d1_mem_rd;
  logic [1:0]    d1_grant;

  mem_arbiter #(.DW(DW), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_ready(cpu_ready), .cpu_rd(cpu_rd),
    .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wd(ld_wd),
    .ld_ready(ld_ready), .ld_rd(ld_rd),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .grant(grant), .busy(busy)
  );

  mem_arbiter #(.DW(DW), .AW(AW), .LAT(LAT1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(d1_cpu_req), .cpu_we(d1_cpu_we), .cpu_adr(d1_cpu_adr), .cpu_wd(d1_cpu_wd),
    .cpu_ready(d1_cpu_ready), .cpu_rd(d1_cpu_rd),
    .ld_req(d1_ld_req), .ld_we(d1_ld_we), .ld_adr(d1_ld_adr), .ld_wd(d1_ld_wd),
    .ld_ready(d1_ld_ready), .ld_rd(d1_ld_rd),
    .mem_we(d1_mem_we), .mem_adr(d1_mem_adr), .mem_wd(d1_mem_wd), .mem_rd(d1_mem_rd),
    .grant(d1_grant), .busy(d1_busy)
  );

  // Memory model: read data is only valid in the last access cycle.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C0F0F;
  endfunction

  int acc_n, acc_n1;
  always @(posedge clk or posedge reset) begin
    if (reset)     acc_n <= 0;
    else if (busy) acc_n <= acc_n + 1;
    else           acc_n <= 0;
  end
  always @(posedge clk or posedge reset) begin
    if (reset)        acc_n1 <= 0;
    else if (d1_busy) acc_n1 <= acc_n1 + 1;
    else              acc_n1 <= 0;
  end
  assign mem_rd    = (busy && acc_n == LAT - 1)     ? mem_fn(mem_adr)    : 32'hBAD0BAD0;
  assign d1_mem_rd = (d1_busy && acc_n1 == LAT1 - 1) ? mem_fn(d1_mem_adr) : 32'hBAD0BAD0;

  int tests = 0;
  int fails = 0;

  // Reference state: last owner (0 CPU, 1 loader) and each port's read register.
  logic          m_last;
  logic [DW-1:0] m_cpu_rd, m_ld_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues the given requests in the current IDLE cycle and checks every cycle
  // until all granted accesses have finished and the arbiter is idle again.
  task automatic run_round(input logic c_en, input logic c_we, input logic [AW-1:0] c_adr,
                           input logic [DW-1:0] c_wd, input logic l_en, input logic l_we,
                           input logic [AW-1:0] l_adr, input logic [DW-1:0] l_wd);
    logic          owners [2];
    int            n;
    logic          o, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
    n = 0;
    if (c_en && l_en) begin
      owners[0] = ~m_last;
      owners[1] = m_last;
      n = 2;
    end else if (c_en || l_en) begin
      owners[0] = l_en;
      n = 1;
    end
    cpu_req = c_en; cpu_we = c_we; cpu_adr = c_adr; cpu_wd = c_wd;
    ld_req  = l_en; ld_we  = l_we; ld_adr  = l_adr; ld_wd  = l_wd;
    for (int i = 0; i < n; i++) begin
      o   = owners[i];
      we  = o ? l_we  : c_we;
      adr = o ? l_adr : c_adr;
      wd  = o ? l_wd  : c_wd;
      for (int k = 1; k <= LAT + 2; k++) begin
        tick();
        check("grant", grant, (k <= LAT + 1) ? (o ? 2'b10 : 2'b01) : 2'b00);
        check("busy", busy, k <= LAT + 1);
        check("mem_we", mem_we, (k == 1) && we);
        check("cpu_ready", cpu_ready, (k == LAT + 1) && !o);
        check("ld_ready", ld_ready, (k == LAT + 1) && o);
        if (k == 1) check("mem_adr", mem_adr, adr);
        if (k == 1 && we) check("mem_wd", mem_wd, wd);
        if (k == LAT + 1) begin
          if (!we) begin
            if (o) m_ld_rd = mem_fn(adr);
            else   m_cpu_rd = mem_fn(adr);
          end
          check("cpu_rd", cpu_rd, m_cpu_rd);
          check("ld_rd", ld_rd, m_ld_rd);
          if (o) ld_req = 1'b0;
          else   cpu_req = 1'b0;
        end
      end
      m_last = o;
    end
    if (n == 0) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          c_en, l_en, c_we, l_we;
    logic [AW-1:0] c_adr, l_adr;
    logic [DW-1:0] c_wd, l_wd;

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0;
    ld_req = 0; ld_we = 0; ld_adr = '0; ld_wd = '0;
    d1_cpu_req = 0; d1_cpu_we = 0; d1_cpu_adr = '0; d1_cpu_wd = '0;
    d1_ld_req = 0; d1_ld_we = 0; d1_ld_adr = '0; d1_ld_wd = '0;
    m_last = 1'b1; m_cpu_rd = '0; m_ld_rd = '0;
    tick();
    tick();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_mem_adr", mem_adr, '0);
    check("rst_mem_wd", mem_wd, '0);
    check("rst_cpu_rd", cpu_rd, '0);
    check("rst_ld_rd", ld_rd, '0);
    reset = 1'b0;

    // Both requesters from reset: CPU, loader, CPU, loader.
    run_round(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
    run_round(1, 1, 32'h38, 32'hA1A2A3A4, 1, 0, 32'h3C, 0);

    // CPU read with known data, then loader write.
    run_round(1, 0, 32'h10, 0, 0, 0, 0, 0);
    check("cpu_read_deadbeef", cpu_rd, 32'hDEADBEEF);
    run_round(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
    check("ld_write_keeps_rd", ld_rd, m_ld_rd);

    // After a lone CPU access, a tie must go to the loader.
    run_round(1, 0, 32'h44, 0, 0, 0, 0, 0);
    run_round(1, 0, 32'h48, 0, 1, 0, 32'h4C, 0);

    // CPU drops req in the second access cycle; the access still completes.
    cpu_req = 1; cpu_we = 0; cpu_adr = 32'h50;
    tick();
    check("drop_grant", grant, 2'b01);
    tick();
    cpu_req = 0;
    check("drop_ready_c2", cpu_ready, 1'b0);
    tick();
    m_cpu_rd = mem_fn(32'h50);
    m_last = 1'b0;
    check("drop_ready_c3", cpu_ready, 1'b1);
    check("drop_rd", cpu_rd, m_cpu_rd);
    tick();
    check("drop_idle_grant", grant, 2'b00);

    // Reset in the first access cycle of a write abandons it.
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h64; cpu_wd = 32'hCAFEF00D;
    tick();
    check("r22_mem_we_pre", mem_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("r22_mem_we", mem_we, 1'b0);
    check("r22_grant", grant, 2'b00);
    check("r22_busy", busy, 1'b0);
    check("r22_mem_adr", mem_adr, '0);
    check("r22_mem_wd", mem_wd, '0);
    check("r22_cpu_rd", cpu_rd, '0);
    check("r22_ld_rd", ld_rd, '0);
    cpu_req = 0;
    @(posedge clk);
    #3 reset = 1'b0;
    m_last = 1'b1; m_cpu_rd = '0; m_ld_rd = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r22_no_ready", {cpu_ready, ld_ready, busy, mem_we}, 4'b0000);
    end
    run_round(1, 0, 32'h10, 0, 1, 1, 32'h68, 32'h55AA55AA);

    // LAT=1 instance: one access cycle, ready in cycle 2.
    d1_cpu_req = 1; d1_cpu_we = 0; d1_cpu_adr = 32'h10;
    tick();
    check("lat1_busy_c1", d1_busy, 1'b1);
    check("lat1_grant_c1", d1_grant, 2'b01);
    check("lat1_ready_c1", d1_cpu_ready, 1'b0);
    tick();
    d1_cpu_req = 0;
    check("lat1_ready_c2", d1_cpu_ready, 1'b1);
    check("lat1_rd", d1_cpu_rd, 32'hDEADBEEF);
    tick();
    check("lat1_ready_c3", d1_cpu_ready, 1'b0);
    check("lat1_busy_c3", d1_busy, 1'b0);

    // Random rounds.
    for (int r = 0; r < 40; r++) begin
      c_en  = 1'($urandom_range(0, 1));
      l_en  = c_en ? 1'($urandom_range(0, 1)) : 1'b1;
      c_we  = 1'($urandom_range(0, 1));
      l_we  = 1'($urandom_range(0, 1));
      c_adr = AW'($urandom_range(0, 255));
      l_adr = AW'($urandom_range(0, 255));
      c_wd  = $urandom;
      l_wd  = $urandom;
      run_round(c_en, c_we, c_adr, c_wd, l_en, l_we, l_adr, l_wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
